// File: rtl/arb_mux_n_pkg.sv
// Shared types for the arb_mux_n merge point: arbitration mode encoding and helpers.
// No logic, no latency, no backpressure: definitions only.
// Optional packet lock is enabled in the top by defining ARB_MUX_LOCK_EN.
package amp_mux_pkg;

    typedef enum logic [1:0] {
        ARB_RR     = 2'd0,
        ARB_FIXED  = 2'd1,
        ARB_STATIC = 2'd2,
        ARB_RSVD   = 2'd3
    } arb_mode_e;

    localparam arb_mode_e ARB_DEFAULT_MODE = ARB_RR;

    // The reserved encoding behaves exactly like round-robin.
    function automatic logic mode_is_rr(input logic [1:0] m);
        return (m == ARB_DEFAULT_MODE) || (m == ARB_RSVD);
    endfunction

endpackage

// File: rtl/arb_mux_n_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load condition.
module rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   ptr,
    output logic [N_CH-1:0] gnt
);

    logic [2*N_CH-1:0] dbl_req;
    logic [N_CH-1:0]   rot_req;
    logic [N_CH-1:0]   rot_gnt;
    logic [2*N_CH-1:0] dbl_gnt;
    logic              found;

    always_comb begin
        dbl_req = {req, req} >> ptr;
        rot_req = dbl_req[N_CH-1:0];
        rot_gnt = '0;
        found   = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (rot_req[i] && !found) begin
                rot_gnt[i] = 1'b1;
                found      = 1'b1;
            end
        end
        // Rotate the winner back into absolute channel positions.
        dbl_gnt = {{N_CH{1'b0}}, rot_gnt} << ptr;
        gnt     = dbl_gnt[N_CH-1:0] | dbl_gnt[2*N_CH-1:N_CH];
    end

endmodule

// File: rtl/arb_mux_n.sv
// N:1 flow-controlled merge with RR/FIXED/STATIC arbitration and optional packet lock (ARB_MUX_LOCK_EN).
// Latency: 1 cycle from input accept to out_valid; one beat per cycle sustained.
// Backpressure: in_ready is zero while the output register holds an unconsumed beat.
module arb_mux_n
    import amp_mux_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int DW   = 32,
    localparam int CW  = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         mode,
    input  logic [CW-1:0]      sel,
    input  logic [N_CH-1:0]    in_valid,
    input  logic [N_CH-1:0]    in_last,
    input  logic [N_CH*DW-1:0] in_data,
    output logic [N_CH-1:0]    in_ready,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_chan,
    output logic               out_last,
    input  logic               out_ready
);

    logic            out_valid_q, out_valid_d;
    logic [DW-1:0]   out_data_q,  out_data_d;
    logic [CW-1:0]   out_chan_q,  out_chan_d;
    logic            out_last_q,  out_last_d;
    logic [CW-1:0]   ptr_q,       ptr_d;
`ifdef ARB_MUX_LOCK_EN
    logic            lock_vld_q,  lock_vld_d;
    logic [CW-1:0]   lock_chan_q, lock_chan_d;
`endif

    logic            load;
    logic [N_CH-1:0] rr_gnt, fixed_gnt, static_gnt, grant, acc_vec;
    logic            accept, adv;
    logic [CW-1:0]   acc_idx;

    rr_arbiter #(.N_CH(N_CH)) u_rr (
        .req (in_valid),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

    always_comb begin
        fixed_gnt  = in_valid & (~in_valid + N_CH'(1));
        static_gnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            static_gnt[i] = in_valid[i] && (sel == CW'(i));
        end
        case (arb_mode_e'(mode))
            ARB_FIXED:  grant = fixed_gnt;
            ARB_STATIC: grant = static_gnt;
            default:    grant = rr_gnt;
        endcase
`ifdef ARB_MUX_LOCK_EN
        if (lock_vld_q) begin
            grant              = '0;
            grant[lock_chan_q] = in_valid[lock_chan_q];
        end
`endif
    end

    // rst_n gates ready so nothing is offered as accepted while reset is held.
    assign load     = !out_valid_q || out_ready;
    assign in_ready = (load && rst_n) ? grant : '0;
    assign acc_vec  = in_valid & in_ready;
    assign accept   = |acc_vec;

    always_comb begin
        acc_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (acc_vec[i]) acc_idx = CW'(i);
        end
    end

`ifdef ARB_MUX_LOCK_EN
    assign adv = accept && in_last[acc_idx] && mode_is_rr(mode);
`else
    assign adv = accept && mode_is_rr(mode);
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
`ifdef ARB_MUX_LOCK_EN
        lock_vld_d  = lock_vld_q;
        lock_chan_d = lock_chan_q;
        if (accept) begin
            lock_vld_d  = !in_last[acc_idx];
            lock_chan_d = acc_idx;
        end
`endif
        if (load) begin
            out_valid_d = accept;
        end
        if (accept) begin
            out_data_d = in_data[int'(acc_idx)*DW +: DW];
            out_chan_d = acc_idx;
            out_last_d = in_last[acc_idx];
        end
        if (adv) begin
            ptr_d = (acc_idx == CW'(N_CH-1)) ? '0 : acc_idx + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_last_q  <= 1'b0;
            ptr_q       <= '0;
`ifdef ARB_MUX_LOCK_EN
            lock_vld_q  <= 1'b0;
            lock_chan_q <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
`ifdef ARB_MUX_LOCK_EN
            lock_vld_q  <= lock_vld_d;
            lock_chan_q <= lock_chan_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_last  = out_last_q;

endmodule
